// File: rtl/weight_load_ctrl.sv
// Weight-load sequencer: reads KERNEL_SIZE weights from a 1-cycle-latency ROM and streams
// them to the PE-array weight port through a 2-entry, credit-tracked output buffer.
`ifndef CNN_KERNEL_SIZE
`define CNN_KERNEL_SIZE 25
`endif
`ifndef CNN_PARA_WIDTH
`define CNN_PARA_WIDTH 16
`endif

module weight_load_ctrl #(
   parameter int unsigned KERNEL_SIZE = `CNN_KERNEL_SIZE,
   parameter int unsigned DATA_WIDTH  = `CNN_PARA_WIDTH,
   parameter int unsigned ADDR_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  rom_r_en,
   output logic [ADDR_WIDTH-1:0] rom_raddr,
   input  logic [DATA_WIDTH-1:0] rom_dout,
   output logic                  w_valid,
   input  logic                  w_ready,
   output logic [DATA_WIDTH-1:0] w_data,
   output logic [ADDR_WIDTH-1:0] w_idx
);

   localparam int unsigned CntWidth = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(KERNEL_SIZE - 1);
   localparam logic [CntWidth-1:0] KernelCnt = CntWidth'(KERNEL_SIZE);

   typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

   state_e state_q, state_d;

   logic [ADDR_WIDTH-1:0] rd_addr_q;
   logic [CntWidth-1:0]   acc_cnt_q;
   logic                  inflight_q;
   logic [ADDR_WIDTH-1:0] inflight_addr_q;
   logic [DATA_WIDTH-1:0] fifo_data_q [2];
   logic [ADDR_WIDTH-1:0] fifo_idx_q  [2];
   logic                  wr_ptr_q;
   logic                  rd_ptr_q;
   logic [1:0]            fifo_cnt_q;

   logic       push;
   logic       pop;
   logic       issue;
   logic       credit_ok;
   logic [2:0] occupancy;

   // Capture is gated by inflight, so the ROM's idle zero output never enters the buffer.
   assign push      = inflight_q;
   assign pop       = w_valid & w_ready;
   assign occupancy = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
   // A pop this cycle frees a slot, letting reads continue at full rate under ready=1.
   assign credit_ok = occupancy < (3'd2 + {2'b00, pop});
   assign issue     = rom_r_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StLoad;
         StLoad:  if (issue && (rd_addr_q == LastAddr)) state_d = StDrain;
         StDrain: if ((acc_cnt_q + CntWidth'(pop)) == KernelCnt) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      rom_r_en  = 1'b0;
      rom_raddr = '0;
      unique case (state_q)
         StLoad: begin
            busy = 1'b1;
            if (credit_ok) begin
               rom_r_en  = 1'b1;
               rom_raddr = rd_addr_q;
            end
         end
         StDrain: busy = 1'b1;
         StDone:  done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_addr_q       <= '0;
         acc_cnt_q       <= '0;
         inflight_q      <= 1'b0;
         inflight_addr_q <= '0;
         wr_ptr_q        <= 1'b0;
         rd_ptr_q        <= 1'b0;
         fifo_cnt_q      <= '0;
      end else begin
         inflight_q      <= issue;
         inflight_addr_q <= rom_raddr;
         if (state_q == StIdle) begin
            rd_addr_q <= '0;
            acc_cnt_q <= '0;
         end else begin
            if (issue) rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
            if (pop)   acc_cnt_q <= acc_cnt_q + CntWidth'(1);
         end
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
         fifo_cnt_q <= fifo_cnt_q + 2'(push) - 2'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data_q[wr_ptr_q] <= rom_dout;
         fifo_idx_q[wr_ptr_q]  <= inflight_addr_q;
      end
   end

   assign w_valid = (fifo_cnt_q != 2'd0);
   // Buffer storage is not reset; gating keeps the outputs at zero while empty.
   assign w_data  = w_valid ? fifo_data_q[rd_ptr_q] : '0;
   assign w_idx   = w_valid ? fifo_idx_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Bench for weight_load_ctrl: scoreboard of expected (idx, data) pairs checked by a monitor,
// plus directed timing checks around start, backpressure, reset and a 1-weight kernel.
module tb_weight_load_ctrl;

   localparam int DW = 16;
   localparam int AW = 5;
   localparam int K  = 25;

   typedef struct packed {
      logic [AW-1:0] idx;
      logic [DW-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic rst       = 1'b1;
   logic start     = 1'b0;
   logic ready_drv = 1'b1;
   logic rand_mode = 1'b0;
   logic rand_bit  = 1'b0;
   logic w_ready;
   assign w_ready = rand_mode ? rand_bit : ready_drv;

   logic          busy, done, rom_r_en, w_valid;
   logic [AW-1:0] rom_raddr, w_idx;
   logic [DW-1:0] rom_dout, w_data;

   logic          start1   = 1'b0;
   logic          w_ready1 = 1'b1;
   logic          busy1, done1, rom_r_en1, w_valid1;
   logic [AW-1:0] rom_raddr1, w_idx1;
   logic [DW-1:0] rom_dout1, w_data1;

   weight_load_ctrl #(.KERNEL_SIZE(K), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .rom_r_en(rom_r_en), .rom_raddr(rom_raddr), .rom_dout(rom_dout),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_idx(w_idx)
   );

   weight_load_ctrl #(.KERNEL_SIZE(1), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
      .rom_r_en(rom_r_en1), .rom_raddr(rom_raddr1), .rom_dout(rom_dout1),
      .w_valid(w_valid1), .w_ready(w_ready1), .w_data(w_data1), .w_idx(w_idx1)
   );

   // ROM models: value = 0x100 + addr, zero when not enabled.
   always @(posedge clk) begin
      rom_dout  <= rom_r_en  ? (DW'('h100) + DW'(rom_raddr))  : '0;
      rom_dout1 <= rom_r_en1 ? (DW'('h100) + DW'(rom_raddr1)) : '0;
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   exp_t sb[$];
   int   xfer_cyc[$];
   int   done_cyc[$];

   initial begin : rand_ready
      forever begin
         @(posedge clk);
         #1 rand_bit = 1'($urandom_range(0, 1));
      end
   end

   initial begin : monitor
      int            outst;
      int            exp_raddr;
      logic          prev_stall;
      logic [DW-1:0] prev_data;
      logic [AW-1:0] prev_idx;
      logic          pop;
      exp_t          e;
      outst = 0;
      exp_raddr = 0;
      prev_stall = 1'b0;
      prev_data = '0;
      prev_idx = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            outst = 0;
            exp_raddr = 0;
            prev_stall = 1'b0;
         end else begin
            pop = w_valid && w_ready;
            if (prev_stall) begin
               check("hold_valid", 32'(w_valid), 1);
               check("hold_data", 32'(w_data), 32'(prev_data));
               check("hold_idx", 32'(w_idx), 32'(prev_idx));
            end
            if (rom_r_en) begin
               check("rd_addr", 32'(rom_raddr), exp_raddr);
               check("credit", 32'((outst - int'(pop)) < 2), 1);
               exp_raddr = (exp_raddr + 1) % K;
            end else begin
               check("raddr_idle", 32'(rom_raddr), 0);
            end
            if (pop) begin
               if (sb.size() == 0) begin
                  check("unexpected_xfer", 1, 0);
               end else begin
                  e = sb.pop_front();
                  check("w_idx", 32'(w_idx), 32'(e.idx));
                  check("w_data", 32'(w_data), 32'(e.data));
               end
               xfer_cyc.push_back(cyc);
            end
            if (done) begin
               check("busy_in_done", 32'(busy), 0);
               done_cyc.push_back(cyc);
            end
            outst = outst + int'(rom_r_en) - int'(pop);
            prev_stall = w_valid && !w_ready;
            prev_data = w_data;
            prev_idx = w_idx;
         end
      end
   end

   task automatic do_start(output int t);
      exp_t e;
      @(posedge clk);
      #1 start = 1'b1;
      for (int i = 0; i < K; i++) begin
         e.idx  = AW'(i);
         e.data = DW'('h100 + i);
         sb.push_back(e);
      end
      @(negedge clk);
      t = cyc;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int base, input int budget);
      int n;
      n = 0;
      while (done_cyc.size() <= base && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", 32'(done_cyc.size() > base), 1);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_rom_r_en"}, 32'(rom_r_en), 0);
      check({tag, "_rom_raddr"}, 32'(rom_raddr), 0);
      check({tag, "_w_valid"}, 32'(w_valid), 0);
      check({tag, "_w_data"}, 32'(w_data), 0);
      check({tag, "_w_idx"}, 32'(w_idx), 0);
   endtask

   initial begin : stim
      int t, xb, db, n;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs_zero("reset");
      check("reset_k1_valid", 32'(w_valid1), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Full-rate load.
      xb = xfer_cyc.size();
      db = done_cyc.size();
      do_start(t);
      @(negedge clk);
      check("t1_busy", 32'(busy), 1);
      check("t1_first_read", 32'(rom_r_en), 1);
      wait_done(db, 100);
      check("t1_xfers", xfer_cyc.size() - xb, K);
      if (xfer_cyc.size() >= xb + K) begin
         check("t1_first_cyc", xfer_cyc[xb] - t, 3);
         check("t1_last_cyc", xfer_cyc[xb + K - 1] - t, 27);
      end
      if (done_cyc.size() > db) check("t1_done_cyc", done_cyc[db] - t, 28);
      repeat (3) @(negedge clk);
      check("t1_done_once", done_cyc.size() - db, 1);

      // Backpressure: ready low through T+10.
      ready_drv = 1'b0;
      xb = xfer_cyc.size();
      db = done_cyc.size();
      do_start(t);
      while (cyc < t + 10) @(negedge clk);
      check("bp_valid", 32'(w_valid), 1);
      check("bp_head_idx", 32'(w_idx), 0);
      check("bp_stalled", 32'(rom_r_en), 0);
      check("bp_no_xfer", xfer_cyc.size() - xb, 0);
      @(posedge clk);
      #1 ready_drv = 1'b1;
      wait_done(db, 200);
      check("bp_xfers", xfer_cyc.size() - xb, K);
      check("bp_sb_empty", sb.size(), 0);

      // Random ready over 5 loads.
      rand_mode = 1'b1;
      for (int l = 0; l < 5; l++) begin
         xb = xfer_cyc.size();
         db = done_cyc.size();
         do_start(t);
         wait_done(db, 400);
         check("rnd_xfers", xfer_cyc.size() - xb, K);
         check("rnd_sb_empty", sb.size(), 0);
      end
      rand_mode = 1'b0;
      ready_drv = 1'b1;
      repeat (2) @(negedge clk);

      // Start pulsed during LOAD and during DONE is ignored.
      xb = xfer_cyc.size();
      db = done_cyc.size();
      do_start(t);
      while (cyc < t + 4) @(negedge clk);
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      while (cyc < t + 27) @(negedge clk);
      @(posedge clk);
      #1 start = 1'b1;
      @(negedge clk);
      check("ign_done_pulse", 32'(done), 1);
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      check("ign_busy_after", 32'(busy), 0);
      check("ign_done_once", done_cyc.size() - db, 1);
      check("ign_xfers", xfer_cyc.size() - xb, K);
      check("ign_sb_empty", sb.size(), 0);

      // Reset mid-load with a read in flight.
      xb = xfer_cyc.size();
      do_start(t);
      n = 0;
      while (xfer_cyc.size() < xb + 10 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("rst_reached_10", 32'(xfer_cyc.size() >= xb + 10), 1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("rst_read_inflight", 32'(rom_r_en), 1);
      @(posedge clk);
      #1 rst = 1'b0;
      sb.delete();
      @(negedge clk);
      check_outputs_zero("midrst");
      xb = xfer_cyc.size();
      repeat (5) @(negedge clk);
      check("midrst_no_late_xfer", xfer_cyc.size() - xb, 0);
      check("midrst_valid_low", 32'(w_valid), 0);
      db = done_cyc.size();
      do_start(t);
      wait_done(db, 100);
      check("midrst_xfers", xfer_cyc.size() - xb, K);
      check("midrst_sb_empty", sb.size(), 0);

      // KERNEL_SIZE = 1 instance.
      @(posedge clk);
      #1 start1 = 1'b1;
      @(negedge clk);
      t = cyc;
      @(posedge clk);
      #1 start1 = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 1) check("k1_busy", 32'(busy1), 1);
         check("k1_valid", 32'(w_valid1), 32'(cyc == t + 3));
         check("k1_done", 32'(done1), 32'(cyc == t + 4));
         if (cyc == t + 3) begin
            check("k1_idx", 32'(w_idx1), 0);
            check("k1_data", 32'(w_data1), 'h100);
         end
      end

      check("sb_empty_end", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
      $fatal(1, "bench timeout");
   end

endmodule
